// File: rtl/id_stage_gen.sv
// Decode stage: regfile with forwarding, load-use and branch hazard stalls, in-ID branch/jump
// resolution, flush and sticky halt. ID/EX bundle is registered; 1-cycle latency.
module id_stage_gen #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_ADDR = 32,
   parameter int NB_CTRL = 16,
   parameter int N_FWD   = 2
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_flush,
   input  logic [NB_DATA-1:0]        i_instruction,
   input  logic [NB_ADDR-1:0]        i_pc,
   input  logic [NB_CTRL-1:0]        i_ctrl,
   input  logic                      i_wb_we,
   input  logic [NB_REG-1:0]         i_wb_addr,
   input  logic [NB_DATA-1:0]        i_wb_data,
   input  logic [N_FWD-1:0]          i_fwd_valid,
   input  logic [N_FWD*NB_REG-1:0]   i_fwd_addr,
   input  logic [N_FWD*NB_DATA-1:0]  i_fwd_data,
   input  logic                      i_ex_reg_write,
   input  logic                      i_ex_mem_read,
   input  logic [NB_REG-1:0]         i_ex_rd,
   input  logic                      i_mem_mem_read,
   input  logic [NB_REG-1:0]         i_mem_rd,
   input  logic [NB_REG-1:0]         i_dbg_addr,
   output logic [NB_DATA-1:0]        o_dbg_data,
   output logic                      o_stall,
   output logic                      o_pc_write,
   output logic                      o_ifid_write,
   output logic                      o_take,
   output logic [NB_ADDR-1:0]        o_target,
   output logic                      o_valid,
   output logic                      o_halt,
   output logic [NB_REG-1:0]         o_rs,
   output logic [NB_REG-1:0]         o_rt,
   output logic [NB_REG-1:0]         o_rd,
   output logic [NB_REG-1:0]         o_shamt,
   output logic [5:0]                o_func,
   output logic [NB_DATA-1:0]        o_data_ra,
   output logic [NB_DATA-1:0]        o_data_rb,
   output logic [NB_DATA-1:0]        o_imm,
   output logic [NB_CTRL-1:0]        o_ctrl,
   output logic [NB_ADDR-1:0]        o_pc_link
);

   localparam int N_REGS = 2**NB_REG;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   logic [NB_DATA-1:0] regs_q [N_REGS];
   logic [NB_DATA-1:0] regs_d [N_REGS];

   logic               valid_q, valid_d;
   logic               halt_q, halt_d;
   logic [NB_REG-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
   logic [5:0]         func_q, func_d;
   logic [NB_DATA-1:0] ra_q, ra_d, rb_q, rb_d, imm_q, imm_d;
   logic [NB_CTRL-1:0] ctrl_q, ctrl_d;
   logic [NB_ADDR-1:0] pc_link_q, pc_link_d;

   logic [5:0]         opcode, funct;
   logic [15:0]        imm16;
   logic [NB_REG-1:0]  rs, rt, rd, shamt;
   logic [NB_DATA-1:0] imm_sext, opnd_a, opnd_b;
   logic               is_branch, is_jump, is_jreg;
   logic               load_use, br_haz, stall, advance, issue, cond;
   logic [NB_ADDR-1:0] target;

   assign opcode = i_instruction[31:26];
   assign funct  = i_instruction[5:0];
   assign imm16  = i_instruction[15:0];
   assign rs     = NB_REG'(i_instruction[25:21]);
   assign rt     = NB_REG'(i_instruction[20:16]);
   assign rd     = NB_REG'(i_instruction[15:11]);
   assign shamt  = NB_REG'(i_instruction[10:6]);
   assign imm_sext = {{(NB_DATA-16){imm16[15]}}, imm16};

   // Lowest forwarding index is youngest, so it is applied last and wins.
   function automatic logic [NB_DATA-1:0] read_opnd(input logic [NB_REG-1:0] r);
      logic [NB_DATA-1:0] v;
      v = regs_q[r];
      if (i_wb_we && i_wb_addr == r) v = i_wb_data;
      for (int k = N_FWD-1; k >= 0; k--) begin
         if (i_fwd_valid[k] && i_fwd_addr[k*NB_REG +: NB_REG] != '0
             && i_fwd_addr[k*NB_REG +: NB_REG] == r)
            v = i_fwd_data[k*NB_DATA +: NB_DATA];
      end
      if (r == '0) v = '0;
      return v;
   endfunction

   function automatic logic src_haz(input logic [NB_REG-1:0] src);
      return (src != '0) && ((i_ex_reg_write && i_ex_rd == src) ||
                             (i_mem_mem_read && i_mem_rd == src));
   endfunction

   always_comb begin
      regs_d = regs_q;
      if (i_wb_we && i_wb_addr != '0) regs_d[i_wb_addr] = i_wb_data;
   end

   always_comb begin
      opnd_a    = read_opnd(rs);
      opnd_b    = read_opnd(rt);
      is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
      is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
      is_jreg   = (opcode == OP_RTYPE) && (funct == FN_JR || funct == FN_JALR);
      load_use  = i_ex_mem_read && (i_ex_rd != '0) && (i_ex_rd == rs || i_ex_rd == rt);
      br_haz    = (is_branch && (src_haz(rs) || src_haz(rt))) || (is_jreg && src_haz(rs));
      // Flush takes priority: a killed instruction never needs to wait.
      stall     = i_enable && !halt_q && !i_flush && (load_use || br_haz);
      advance   = i_enable && !halt_q && !stall;
      issue     = i_enable && !halt_q && !stall && !i_flush;

      cond   = 1'b0;
      target = '0;
      if (is_branch) begin
         cond   = (opcode == OP_BEQ) ? (opnd_a == opnd_b) : (opnd_a != opnd_b);
         target = i_pc + NB_ADDR'($signed(imm16));
      end else if (is_jump) begin
         cond   = 1'b1;
         target = NB_ADDR'(i_instruction[25:0]);
      end else if (is_jreg) begin
         cond   = 1'b1;
         target = NB_ADDR'(opnd_a);
      end
   end

   always_comb begin
      valid_d   = valid_q;
      halt_d    = halt_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      shamt_d   = shamt_q;
      func_d    = func_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      imm_d     = imm_q;
      ctrl_d    = ctrl_q;
      pc_link_d = pc_link_q;
      if (i_enable) begin
         if (stall || i_flush || halt_q) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end else begin
            valid_d   = 1'b1;
            rs_d      = rs;
            rt_d      = rt;
            rd_d      = rd;
            shamt_d   = shamt;
            func_d    = funct;
            ra_d      = opnd_a;
            rb_d      = opnd_b;
            imm_d     = imm_sext;
            ctrl_d    = i_ctrl;
            pc_link_d = i_pc;
            if (opcode == OP_HALT) halt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
         valid_q   <= 1'b0;
         halt_q    <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         shamt_q   <= '0;
         func_q    <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         imm_q     <= '0;
         ctrl_q    <= '0;
         pc_link_q <= '0;
      end else begin
         regs_q    <= regs_d;
         valid_q   <= valid_d;
         halt_q    <= halt_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         shamt_q   <= shamt_d;
         func_q    <= func_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         imm_q     <= imm_d;
         ctrl_q    <= ctrl_d;
         pc_link_q <= pc_link_d;
      end
   end

   assign o_dbg_data   = regs_q[i_dbg_addr];
   assign o_stall      = stall;
   assign o_pc_write   = advance;
   assign o_ifid_write = advance;
   assign o_take       = issue && cond;
   assign o_target     = target;
   assign o_valid      = valid_q;
   assign o_halt       = halt_q;
   assign o_rs         = rs_q;
   assign o_rt         = rt_q;
   assign o_rd         = rd_q;
   assign o_shamt      = shamt_q;
   assign o_func       = func_q;
   assign o_data_ra    = ra_q;
   assign o_data_rb    = rb_q;
   assign o_imm        = imm_q;
   assign o_ctrl       = ctrl_q;
   assign o_pc_link    = pc_link_q;

endmodule

// File: tb/tb_id_stage_gen.sv
// Bench for id_stage_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage_gen;
   logic        clk, rst, en, flush;
   logic [31:0] instr, pc;
   logic [15:0] ctrl;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  fwd_valid;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic        ex_reg_write, ex_mem_read, mem_mem_read;
   logic [4:0]  ex_rd, mem_rd, dbg_addr;
   logic [31:0] dbg_data, data_ra, data_rb, imm, target, pc_link;
   logic        stall, pc_write, ifid_write, take, valid, halt;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  func;
   logic [15:0] octrl;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   logic [31:0] m_regs [32];
   logic        m_valid, m_halt;
   logic [15:0] m_ctrl;
   logic [31:0] m_ra, m_rb, m_imm, m_pclink;
   logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
   logic [5:0]  m_func;
   logic        e_stall, e_pcw, e_take;
   logic [31:0] e_target;

   id_stage_gen dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(flush),
      .i_instruction(instr), .i_pc(pc), .i_ctrl(ctrl),
      .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr), .i_fwd_data(fwd_data),
      .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
      .i_mem_mem_read(mem_mem_read), .i_mem_rd(mem_rd),
      .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data),
      .o_stall(stall), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
      .o_take(take), .o_target(target), .o_valid(valid), .o_halt(halt),
      .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_shamt(shamt), .o_func(func),
      .o_data_ra(data_ra), .o_data_rb(data_rb), .o_imm(imm),
      .o_ctrl(octrl), .o_pc_link(pc_link)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      for (int k = 0; k < 2; k++)
         if (fwd_valid[k] && fwd_addr[k*5 +: 5] != 5'd0 && fwd_addr[k*5 +: 5] == r)
            return fwd_data[k*32 +: 32];
      if (wb_we && wb_addr == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic logic m_busy(input logic [4:0] s);
      return s != 5'd0 && ((ex_reg_write && ex_rd == s) || (mem_mem_read && mem_rd == s));
   endfunction

   task automatic model_comb();
      logic [5:0] op, fn;
      logic [4:0] s, t;
      logic br, jr, jj, lu, bh, c;
      op = instr[31:26]; fn = instr[5:0]; s = instr[25:21]; t = instr[20:16];
      br = (op == 6'h04) || (op == 6'h05);
      jj = (op == 6'h02) || (op == 6'h03);
      jr = (op == 6'h00) && (fn == 6'h08 || fn == 6'h09);
      lu = ex_mem_read && ex_rd != 5'd0 && (ex_rd == s || ex_rd == t);
      bh = br ? (m_busy(s) || m_busy(t)) : (jr ? m_busy(s) : 1'b0);
      e_stall = en && !m_halt && !flush && (lu || bh);
      e_pcw   = en && !m_halt && !e_stall;
      c = (op == 6'h04) ? (m_read(s) == m_read(t)) :
          (op == 6'h05) ? (m_read(s) != m_read(t)) : (jj || jr);
      e_take = en && !e_stall && !m_halt && !flush && c;
      if (br)      e_target = pc + {{16{instr[15]}}, instr[15:0]};
      else if (jj) e_target = {6'd0, instr[25:0]};
      else if (jr) e_target = m_read(s);
      else         e_target = 32'd0;
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_valid = 0; m_halt = 0; m_ctrl = 0; m_ra = 0; m_rb = 0; m_imm = 0; m_pclink = 0;
         m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_func = 0;
      end else begin
         if (en) begin
            if (e_stall || flush || m_halt) begin
               m_valid = 0; m_ctrl = 0;
            end else begin
               m_valid = 1; m_ctrl = ctrl; m_pclink = pc;
               m_ra = m_read(instr[25:21]); m_rb = m_read(instr[20:16]);
               m_imm = {{16{instr[15]}}, instr[15:0]};
               m_rs = instr[25:21]; m_rt = instr[20:16]; m_rd = instr[15:11];
               m_shamt = instr[10:6]; m_func = instr[5:0];
               if (instr[31:26] == 6'h3F) m_halt = 1;
            end
         end
         if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      end
   endtask

   task automatic tick();
      model_comb();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle();
      en = 1; flush = 0; instr = 32'd0; pc = 32'd0; ctrl = 16'd0;
      wb_we = 0; wb_addr = 0; wb_data = 0; fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0; dbg_addr = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1; instr = 32'h0021_2020; ctrl = 16'hFFFF; wb_we = 1; wb_addr = 5; wb_data = 32'h55;
      tick(); tick();
      rst = 0; set_idle(); dbg_addr = 5; #1;
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h want 0", valid); end
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %h want 0", halt); end
      n_cmp++; if (octrl !== 16'd0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", octrl); end
      n_cmp++; if (pc_link !== 32'd0) begin n_err++; $display("FAIL reset_pclink got %h want 0", pc_link); end
      n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL reset_reg5 got %h want 0", dbg_data); end
   endtask

   task automatic test_wb_bypass();
      set_idle();
      wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; ctrl = 16'h00A5;
      instr = {6'h00, 5'd5, 5'd0, 5'd9, 5'd0, 6'h20};
      tick();
      n_cmp++; if (data_ra !== 32'hDEADBEEF) begin n_err++; $display("FAIL wt_ra got %h want deadbeef", data_ra); end
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL wt_valid got %h want 1", valid); end
      n_cmp++; if (octrl !== 16'h00A5) begin n_err++; $display("FAIL wt_ctrl got %h want 00a5", octrl); end
      wb_addr = 0; wb_data = 32'd1; instr = {6'h00, 5'd0, 5'd5, 5'd9, 5'd0, 6'h20};
      tick();
      n_cmp++; if (data_ra !== 32'd0) begin n_err++; $display("FAIL r0_ra got %h want 0", data_ra); end
      n_cmp++; if (data_rb !== 32'hDEADBEEF) begin n_err++; $display("FAIL r5_rb got %h want deadbeef", data_rb); end
      wb_we = 0; dbg_addr = 0; #1;
      n_cmp++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL r0_dbg got %h want 0", dbg_data); end
   endtask

   task automatic test_load_use();
      set_idle();
      ex_mem_read = 1; ex_rd = 3; ctrl = 16'h1234;
      instr = {6'h00, 5'd3, 5'd4, 5'd6, 5'd0, 6'h20};
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %h want 1", stall); end
      n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL lu_pcw got %h want 0", pc_write); end
      n_cmp++; if (ifid_write !== 1'b0) begin n_err++; $display("FAIL lu_ifid got %h want 0", ifid_write); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %h want 0", valid); end
      n_cmp++; if (octrl !== 16'd0) begin n_err++; $display("FAIL lu_bctrl got %h want 0", octrl); end
      ex_mem_read = 0; #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release got %h want 0", stall); end
      tick();
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL lu_cap_valid got %h want 1", valid); end
      n_cmp++; if (octrl !== 16'h1234) begin n_err++; $display("FAIL lu_cap_ctrl got %h want 1234", octrl); end
   endtask

   task automatic test_branch();
      set_idle();
      wb_we = 1; wb_addr = 1; wb_data = 32'd7; tick();
      wb_addr = 2; tick();
      wb_we = 0; pc = 32'h10;
      instr = {6'h04, 5'd1, 5'd2, 16'hFFFC}; #1;
      n_cmp++; if (take !== 1'b1) begin n_err++; $display("FAIL beq_take got %h want 1", take); end
      n_cmp++; if (target !== 32'h0C) begin n_err++; $display("FAIL beq_target got %h want c", target); end
      instr = {6'h05, 5'd1, 5'd2, 16'hFFFC}; #1;
      n_cmp++; if (take !== 1'b0) begin n_err++; $display("FAIL bne_take got %h want 0", take); end
      n_cmp++; if (target !== 32'h0C) begin n_err++; $display("FAIL bne_target got %h want c", target); end
      tick();
   endtask

   task automatic test_branch_haz();
      set_idle();
      wb_we = 1; wb_addr = 2; wb_data = 32'd1; tick();
      wb_we = 0; pc = 32'h20; instr = {6'h04, 5'd1, 5'd2, 16'h0008};
      ex_reg_write = 1; ex_rd = 1; #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL bh_stall got %h want 1", stall); end
      n_cmp++; if (take !== 1'b0) begin n_err++; $display("FAIL bh_take got %h want 0", take); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL bh_bubble got %h want 0", valid); end
      ex_reg_write = 0; fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'd2, 32'd1}; #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL bh_go got %h want 0", stall); end
      n_cmp++; if (take !== 1'b1) begin n_err++; $display("FAIL fwd_prio_take got %h want 1", take); end
      n_cmp++; if (target !== 32'h28) begin n_err++; $display("FAIL bh_target got %h want 28", target); end
      tick();
      n_cmp++; if (data_ra !== 32'd1) begin n_err++; $display("FAIL fwd_prio_ra got %h want 1", data_ra); end
   endtask

   task automatic test_enable_flush();
      logic [31:0] s_ra, s_pcl;
      logic [15:0] s_ctrl;
      set_idle();
      instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; ctrl = 16'h0F0F; pc = 32'h44;
      tick();
      s_ra = m_ra; s_pcl = m_pclink; s_ctrl = m_ctrl;
      en = 0;
      for (int i = 0; i < 3; i++) begin
         instr = $urandom; ctrl = 16'($urandom); pc = $urandom; #1;
         n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL en0_pcw got %h want 0", pc_write); end
         tick();
         n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL en0_valid got %h want 1", valid); end
         n_cmp++; if (octrl !== s_ctrl) begin n_err++; $display("FAIL en0_ctrl got %h want %h", octrl, s_ctrl); end
         n_cmp++; if (data_ra !== s_ra) begin n_err++; $display("FAIL en0_ra got %h want %h", data_ra, s_ra); end
         n_cmp++; if (pc_link !== s_pcl) begin n_err++; $display("FAIL en0_pcl got %h want %h", pc_link, s_pcl); end
      end
      set_idle();
      flush = 1; ex_mem_read = 1; ex_rd = 3; ctrl = 16'h7777;
      instr = {6'h00, 5'd3, 5'd0, 5'd4, 5'd0, 6'h20}; #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %h want 0", stall); end
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %h want 0", valid); end
      n_cmp++; if (octrl !== 16'd0) begin n_err++; $display("FAIL flush_ctrl got %h want 0", octrl); end
   endtask

   task automatic test_random();
      logic [5:0] op;
      logic [5:0] fns [3];
      fns[0] = 6'h20; fns[1] = 6'h08; fns[2] = 6'h09;
      for (int n = 0; n < 400; n++) begin
         set_idle();
         case ($urandom_range(0, 7))
            0: op = 6'h00; 1: op = 6'h04; 2: op = 6'h05; 3: op = 6'h02;
            4: op = 6'h03; 5: op = 6'h23; 6: op = 6'h00;
            default: op = 6'($urandom_range(6, 62));
         endcase
         instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
         if (op == 6'h00) instr[5:0] = fns[$urandom_range(0, 2)];
         pc = $urandom; ctrl = 16'($urandom);
         en = ($urandom_range(0, 9) != 0); flush = ($urandom_range(0, 9) == 0);
         wb_we = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 4)); wb_data = $urandom_range(0, 3);
         fwd_valid = 2'($urandom); fwd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_data = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
         ex_reg_write = ($urandom_range(0, 3) == 0); ex_mem_read = ($urandom_range(0, 3) == 0);
         ex_rd = 5'($urandom_range(0, 3)); mem_mem_read = ($urandom_range(0, 3) == 0);
         mem_rd = 5'($urandom_range(0, 3)); dbg_addr = 5'($urandom_range(0, 4));
         #1; model_comb();
         n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall n=%0d got %h want %h", n, stall, e_stall); end
         n_cmp++; if (pc_write !== e_pcw || ifid_write !== e_pcw) begin n_err++; $display("FAIL rnd_pcw n=%0d got %h/%h want %h", n, pc_write, ifid_write, e_pcw); end
         n_cmp++; if (take !== e_take) begin n_err++; $display("FAIL rnd_take n=%0d got %h want %h", n, take, e_take); end
         n_cmp++; if (target !== e_target) begin n_err++; $display("FAIL rnd_target n=%0d got %h want %h", n, target, e_target); end
         n_cmp++; if (dbg_data !== m_regs[dbg_addr]) begin n_err++; $display("FAIL rnd_dbg n=%0d got %h want %h", n, dbg_data, m_regs[dbg_addr]); end
         tick();
         n_cmp++; if (valid !== m_valid || octrl !== m_ctrl || halt !== m_halt) begin n_err++; $display("FAIL rnd_ctl n=%0d got %h/%h/%h want %h/%h/%h", n, valid, octrl, halt, m_valid, m_ctrl, m_halt); end
         if (m_valid) begin
            n_cmp++; if (data_ra !== m_ra || data_rb !== m_rb) begin n_err++; $display("FAIL rnd_opnd n=%0d got %h/%h want %h/%h", n, data_ra, data_rb, m_ra, m_rb); end
            n_cmp++; if (imm !== m_imm || pc_link !== m_pclink) begin n_err++; $display("FAIL rnd_imm_pcl n=%0d got %h/%h want %h/%h", n, imm, pc_link, m_imm, m_pclink); end
            n_cmp++; if ({rs, rt, rd, shamt, func} !== {m_rs, m_rt, m_rd, m_shamt, m_func}) begin n_err++; $display("FAIL rnd_fields n=%0d got %h want %h", n, {rs, rt, rd, shamt, func}, {m_rs, m_rt, m_rd, m_shamt, m_func}); end
         end
      end
   endtask

   task automatic test_halt();
      set_idle();
      instr = {6'h3F, 26'd0}; ctrl = 16'h5A5A; #1;
      n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL pre_halt_pcw got %h want 1", pc_write); end
      tick();
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set got %h want 1", halt); end
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL halt_valid got %h want 1", valid); end
      n_cmp++; if (octrl !== 16'h5A5A) begin n_err++; $display("FAIL halt_ctrl got %h want 5a5a", octrl); end
      n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL halt_pcw got %h want 0", pc_write); end
      instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; ctrl = 16'h1111;
      wb_we = 1; wb_addr = 7; wb_data = 32'h1234; dbg_addr = 7;
      tick();
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_sticky got %h want 1", halt); end
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL halt_bubble got %h want 0", valid); end
      n_cmp++; if (dbg_data !== 32'h1234) begin n_err++; $display("FAIL halt_wb got %h want 1234", dbg_data); end
      rst = 1; tick(); rst = 0; #1;
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL halt_clear got %h want 0", halt); end
   endtask

   initial begin
      rst = 1;
      set_idle();
      test_reset();
      test_wb_bypass();
      test_load_use();
      test_branch();
      test_branch_haz();
      test_enable_flush();
      test_random();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
